// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks destination registers of in-flight
// instructions and raises a RAW stall for the instruction in decode.
module issue_scoreboard #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_in,
    input  logic             issue_writes_rd_in,
    input  logic [4:0]       issue_rd_address_in,
    input  logic [4:0]       rs1_address_in,
    input  logic [4:0]       rs2_address_in,
    input  logic             retire_valid_in,
    input  logic [4:0]       retire_rd_address_in,
    input  logic             flush_in,
    output logic             issue_accept_out,
    output logic             stall_out,
    output logic             rs1_busy_out,
    output logic             rs2_busy_out,
    output logic             full_out,
    output logic             empty_out,
    output logic [CNT_W-1:0] inflight_count_out,
    output logic             order_error_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [4:0] rd_q [DEPTH];
    logic [4:0] rd_d [DEPTH];
    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    cnt_t       count_q, count_d;
    cnt_t       pending_q [1:31];
    cnt_t       pending_d [1:31];
    logic       order_err_q, order_err_d;

    logic        full;
    logic        empty;
    logic [31:0] pend_nz;
    logic [4:0]  issue_rd;
    logic [4:0]  head_rd;
    logic        accept;
    logic        pop;
    logic        stall;

    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_inc = (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == cnt_t'(DEPTH));
    assign empty    = (count_q == '0);
    assign issue_rd = issue_writes_rd_in ? issue_rd_address_in : 5'd0;
    assign head_rd  = rd_q[head_q];

    // x0 is never tracked, so bit 0 of the busy vector stays low.
    always_comb begin
        pend_nz = '0;
        for (int i = 1; i < 32; i++) begin
            pend_nz[i] = |pending_q[i];
        end
    end

    assign rs1_busy_out = pend_nz[rs1_address_in];
    assign rs2_busy_out = pend_nz[rs2_address_in];

    assign stall  = issue_valid_in
                  && (full || rs1_busy_out || rs2_busy_out);
    assign accept = issue_valid_in && !stall && !flush_in;
    assign pop    = retire_valid_in && !empty && !flush_in;

    assign stall_out          = stall;
    assign issue_accept_out   = accept;
    assign full_out           = full;
    assign empty_out          = empty;
    assign inflight_count_out = count_q;
    assign order_error_out    = order_err_q;

    always_comb begin
        rd_d        = rd_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        pending_d   = pending_q;
        order_err_d = order_err_q;

        if (flush_in) begin
            head_d  = tail_q;
            count_d = '0;
            for (int i = 1; i < 32; i++) begin
                pending_d[i] = '0;
            end
        end else begin
            if (accept) begin
                rd_d[tail_q] = issue_rd;
                tail_d       = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end

            unique case ({accept, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            // Same-rd issue and retire cancel out in the counter.
            for (int i = 1; i < 32; i++) begin
                unique case ({accept && (issue_rd == i[4:0]),
                              pop && (head_rd == i[4:0])})
                    2'b10:   pending_d[i] = pending_q[i] + 1'b1;
                    2'b01:   pending_d[i] = pending_q[i] - 1'b1;
                    default: pending_d[i] = pending_q[i];
                endcase
            end

            if (retire_valid_in) begin
                if (empty || (retire_rd_address_in != head_rd)) begin
                    order_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 1; i < 32; i++) begin
                pending_q[i] <= '0;
            end
            order_err_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
            order_err_q <= order_err_d;
        end
    end

endmodule
